// File: rtl/q2_sequencer.sv
// q2_sequencer: instruction-cycle control sequencer for the widened Q2 datapath.
// Walks FETCH/DEREF/LOAD/EXEC plus serial SHIFT and decodes one-hot datapath strobes
// from the registered state, phase and count. It also services front-panel deposit
// and increment-P while halted.
// Optional feature: define Q2_SINGLE_STEP_EN to enable single-instruction stepping.
module q2_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             dep_sw,
  input  logic             incp_sw,
  input  logic             mem_rdy,
  input  logic [2:0]       ir_op,
  input  logic             ir_deref,
  input  logic [CNT_W-1:0] x_lo,
  input  logic             f,
  output logic [2:0]       state_o,
  output logic             addr_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             x_wr,
  output logic             a_wr,
  output logic [1:0]       a_sel,
  output logic             p_wr,
  output logic             p_inc,
  output logic             f_wr,
  output logic             f_sel
);

  // DEP and INCP are front-panel sub-states that report as IDLE on the lamps
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DEREF = 3'd2,
    S_LOAD  = 3'd3,
    S_EXEC  = 3'd4,
    S_SHIFT = 3'd5,
    S_DEP   = 3'd6,
    S_INCP  = 3'd7
  } state_t;

  localparam logic [2:0] OP_SRC = 3'd2;
  localparam logic [2:0] OP_STA = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_JNF = 3'd7;

  state_t           state, state_n, end_state;
  logic             phase, phase_n;
  logic [CNT_W-1:0] count, count_n;
  logic             dep_q, incp_q;
  logic             dep_rise, incp_rise;
  logic             mem_acc;
  logic             single, single_n;
  logic             step_rise;
  logic [31:0]      width_unused;

  assign width_unused = 32'(WIDTH);
  assign dep_rise     = dep_sw & ~dep_q;
  assign incp_rise    = incp_sw & ~incp_q;

`ifdef Q2_SINGLE_STEP_EN
  logic step_q;

  // step edge history and single-instruction flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
      single <= 1'b0;
    end else begin
      step_q <= step;
      single <= single_n;
    end
  end

  assign step_rise = step & ~step_q;
  assign end_state = (run && !single) ? S_FETCH : S_IDLE;
`else
  logic step_unused;

  assign step_unused = step;
  assign step_rise   = 1'b0;
  assign single      = 1'b0;
  assign end_state   = run ? S_FETCH : S_IDLE;
`endif

  // state, phase, shift count and switch edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      phase  <= 1'b0;
      count  <= '0;
      dep_q  <= 1'b0;
      incp_q <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      count  <= count_n;
      dep_q  <= dep_sw;
      incp_q <= incp_sw;
    end
  end

  // next-state and strobe decode
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    count_n  = count;
    single_n = single;
    mem_acc  = 1'b0;
    state_o  = 3'd0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    x_wr     = 1'b0;
    a_wr     = 1'b0;
    a_sel    = 2'd0;
    p_wr     = 1'b0;
    p_inc    = 1'b0;
    f_wr     = 1'b0;
    f_sel    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_n = S_FETCH;
        end else if (step_rise) begin
          state_n  = S_FETCH;
          single_n = 1'b1;
        end else if (dep_rise) begin
          state_n = S_DEP;
        end else if (incp_rise) begin
          state_n = S_INCP;
        end
      end
      S_FETCH: begin
        state_o = 3'd1;
        mem_acc = 1'b1;
        mem_rd  = 1'b1;
        if (phase) begin
          ir_wr   = 1'b1;
          x_wr    = 1'b1;
          p_inc   = 1'b1;
          phase_n = 1'b0;
          if (ir_deref)            state_n = S_DEREF;
          else if (ir_op < 3'd4)   state_n = S_LOAD;
          else                     state_n = S_EXEC;
        end
      end
      S_DEREF: begin
        state_o  = 3'd2;
        mem_acc  = 1'b1;
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        if (phase) begin
          x_wr    = 1'b1;
          phase_n = 1'b0;
          state_n = (ir_op < 3'd4) ? S_LOAD : S_EXEC;
        end
      end
      S_LOAD: begin
        state_o  = 3'd3;
        mem_acc  = 1'b1;
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        if (phase) begin
          x_wr    = 1'b1;
          phase_n = 1'b0;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        state_o = 3'd4;
        if (ir_op == OP_STA) begin
          mem_acc  = 1'b1;
          addr_sel = 1'b1;
          mem_wr   = 1'b1;
        end
        if (phase) begin
          phase_n = 1'b0;
          case (ir_op)
            3'd0: begin
              a_wr = 1'b1;
              f_wr = 1'b1;
            end
            3'd1: begin
              a_wr  = 1'b1;
              a_sel = 2'd1;
            end
            3'd3, 3'd4: begin
              a_wr  = 1'b1;
              a_sel = 2'd2;
            end
            OP_JMP: p_wr = 1'b1;
            OP_JNF: p_wr = ~f;
            default: ;
          endcase
          if (ir_op == OP_SRC) count_n = x_lo;
          if (ir_op == OP_SRC && x_lo != '0) begin
            state_n = S_SHIFT;
          end else begin
            state_n  = end_state;
            single_n = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        state_o = 3'd5;
        a_wr    = 1'b1;
        a_sel   = 2'd3;
        f_wr    = 1'b1;
        f_sel   = 1'b1;
        count_n = count - CNT_W'(1);
        if (count <= CNT_W'(1)) begin
          state_n  = end_state;
          single_n = 1'b0;
        end
      end
      S_DEP: begin
        mem_acc = 1'b1;
        mem_wr  = ~phase;
        p_inc   = phase;
        if (phase) begin
          phase_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_INCP: begin
        p_inc   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // phase A advances immediately, or on mem_rdy for memory states
    if (!phase && (state == S_FETCH || state == S_DEREF || state == S_LOAD ||
                   state == S_EXEC || state == S_DEP)) begin
      if (!mem_acc || mem_rdy) phase_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_q2_sequencer.sv
// Self-checking bench for q2_sequencer: a per-instruction trace model expands each
// instruction into its expected cycle-by-cycle lamp/strobe pattern and input drive.
module tb_q2_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, run, step, dep_sw, incp_sw, mem_rdy, ir_deref, f;
  logic [2:0]       ir_op;
  logic [CNT_W-1:0] x_lo;
  logic [2:0]       state_o;
  logic             addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, p_wr, p_inc, f_wr, f_sel;
  logic [1:0]       a_sel;

  q2_sequencer #(.WIDTH(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .dep_sw(dep_sw), .incp_sw(incp_sw),
    .mem_rdy(mem_rdy), .ir_op(ir_op), .ir_deref(ir_deref), .x_lo(x_lo), .f(f),
    .state_o(state_o), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_wr(ir_wr), .x_wr(x_wr), .a_wr(a_wr), .a_sel(a_sel), .p_wr(p_wr), .p_inc(p_inc),
    .f_wr(f_wr), .f_sel(f_sel)
  );

  always #5 clk = ~clk;

  // output vector: {state_o, addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel}
  localparam logic [14:0] B_AS  = 15'h0800;
  localparam logic [14:0] B_RD  = 15'h0400;
  localparam logic [14:0] B_WR  = 15'h0200;
  localparam logic [14:0] B_IRW = 15'h0100;
  localparam logic [14:0] B_XW  = 15'h0080;
  localparam logic [14:0] B_AW  = 15'h0040;
  localparam logic [14:0] B_P   = 15'h0008;
  localparam logic [14:0] B_PI  = 15'h0004;
  localparam logic [14:0] B_FW  = 15'h0002;
  localparam logic [14:0] B_FS  = 15'h0001;

  typedef struct packed {
    logic [14:0] o;
    logic        rdy, run, dep, incp, stp, deref, fv;
    logic [2:0]  op;
    logic [3:0]  xlo;
  } cyc_t;

  cyc_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  logic       cur_run, cur_dep, cur_incp, cur_step, cur_deref, cur_fv;
  logic [2:0] cur_op;
  logic [3:0] cur_xlo;
  int         wsel = -1;
  bit         fast = 1'b0;

  function automatic logic [14:0] st(input logic [2:0] s);
    st = {s, 12'h000};
  endfunction

  function automatic logic [14:0] asl(input logic [1:0] s);
    asl = {9'h000, s, 4'h0};
  endfunction

  function automatic logic rnd();
    rnd = 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [14:0] o, input logic rdy);
    cyc_t c;
    c.o = o; c.rdy = fast ? 1'b1 : rdy; c.run = cur_run; c.dep = cur_dep;
    c.incp = cur_incp; c.stp = cur_step; c.deref = cur_deref; c.fv = cur_fv;
    c.op = cur_op; c.xlo = cur_xlo;
    exp_q.push_back(c);
  endtask

  // phase A of a memory access: wait cycles with mem_rdy low, then the ready cycle
  task automatic mem(input logic [14:0] o);
    int w;
    w = fast ? 0 : ((wsel >= 0) ? wsel : int'($urandom_range(0, 3)));
    repeat (w) push(o, 1'b0);
    push(o, 1'b1);
  endtask

  task automatic idle(input int n, input logic rn);
    cur_run = rn;
    repeat (n) push(st(3'd0), rnd());
  endtask

  // one whole instruction, from its first FETCH cycle to its last cycle
  task automatic add_instr(input logic [2:0] op, input logic dr, input logic [3:0] xl,
                           input logic fv, input logic rn);
    cur_op = op; cur_deref = dr; cur_xlo = xl; cur_fv = fv; cur_run = rn;
    mem(st(3'd1) | B_RD);
    push(st(3'd1) | B_RD | B_IRW | B_XW | B_PI, rnd());
    if (dr) begin
      mem(st(3'd2) | B_AS | B_RD);
      push(st(3'd2) | B_AS | B_RD | B_XW, rnd());
    end
    if (op < 3'd4) begin
      mem(st(3'd3) | B_AS | B_RD);
      push(st(3'd3) | B_AS | B_RD | B_XW, rnd());
    end
    if (op == 3'd5) mem(st(3'd4) | B_AS | B_WR);
    else            push(st(3'd4), rnd());
    case (op)
      3'd0: push(st(3'd4) | B_AW | asl(2'd0) | B_FW, rnd());
      3'd1: push(st(3'd4) | B_AW | asl(2'd1), rnd());
      3'd2: push(st(3'd4), rnd());
      3'd3, 3'd4: push(st(3'd4) | B_AW | asl(2'd2), rnd());
      3'd5: push(st(3'd4) | B_AS | B_WR, rnd());
      3'd6: push(st(3'd4) | B_P, rnd());
      default: push(fv ? st(3'd4) : (st(3'd4) | B_P), rnd());
    endcase
    if (op == 3'd2)
      for (int i = 0; i < int'(xl); i++) push(st(3'd5) | B_AW | asl(2'd3) | B_FW | B_FS, rnd());
  endtask

  // drive one cycle from the model and sample outputs mid-cycle
  task automatic play_cycle(output logic [14:0] e, output logic [14:0] a, output logic [14:0] m);
    cyc_t c;
    c = exp_q.pop_front();
    @(posedge clk);
    #1;
    mem_rdy = c.rdy; run = c.run; dep_sw = c.dep; incp_sw = c.incp; step = c.stp;
    ir_op = c.op; ir_deref = c.deref; x_lo = c.xlo; f = c.fv;
    #1;
    a = {state_o, addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel};
    e = c.o;
    m = 15'h7FFF;
    if (!(e[10] | e[9])) m[11] = 1'b0;
    if (!e[6]) m[5:4] = 2'b00;
    if (!e[1]) m[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; dep_sw = 1'b0; incp_sw = 1'b0; mem_rdy = 1'b0;
    ir_op = 3'd0; ir_deref = 1'b0; x_lo = '0; f = 1'b0;
    cur_run = 0; cur_dep = 0; cur_incp = 0; cur_step = 0; cur_deref = 0; cur_fv = 0;
    cur_op = 0; cur_xlo = 0;
    #2;
    checks++;
    if ({state_o, addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel} !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0000", {state_o, addr_sel, mem_rd, mem_wr, ir_wr,
               x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_fast();
    logic [14:0] e, a, m;
    fast = 1'b1;
    idle(1, 1'b1);
    add_instr(3'd0, 1'b0, 4'd5, 1'b0, 1'b1);
    add_instr(3'd1, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    fast = 1'b0;
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL add_fast got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_shift();
    logic [14:0] e, a, m;
    idle(1, 1'b1);
    add_instr(3'd2, 1'b0, 4'd3, 1'b0, 1'b1);
    add_instr(3'd2, 1'b0, 4'd0, 1'b1, 1'b1);
    add_instr(3'd2, 1'b0, 4'd15, 1'b0, 1'b1);
    add_instr(3'd3, 1'b1, 4'd7, 1'b0, 1'b0);
    idle(2, 1'b0);
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL shift got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_jumps();
    logic [14:0] e, a, m;
    idle(1, 1'b1);
    add_instr(3'd7, 1'b0, 4'd0, 1'b1, 1'b1);
    add_instr(3'd7, 1'b0, 4'd0, 1'b0, 1'b1);
    add_instr(3'd6, 1'b1, 4'd0, 1'b0, 1'b1);
    add_instr(3'd4, 1'b1, 4'd0, 1'b0, 1'b1);
    add_instr(3'd5, 1'b1, 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL jumps got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [14:0] e, a, m;
    idle(1, 1'b1);
    wsel = 3;
    add_instr(3'd3, 1'b0, 4'd0, 1'b0, 1'b1);
    add_instr(3'd5, 1'b0, 4'd0, 1'b0, 1'b0);
    wsel = -1;
    idle(1, 1'b0);
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL mem_wait got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] e, a, m;
    logic rn;
    idle(1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      rn = ($urandom_range(0, 3) != 0);
      add_instr(3'($urandom_range(0, 7)), rnd(), 4'($urandom_range(0, 15)), rnd(), rn);
      if (!rn) begin
        idle(int'($urandom_range(1, 3)), 1'b0);
        idle(1, 1'b1);
      end
    end
    add_instr(3'($urandom_range(0, 7)), rnd(), 4'($urandom_range(0, 15)), rnd(), 1'b0);
    idle(2, 1'b0);
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL random got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_switches();
    logic [14:0] e, a, m;
    idle(1, 1'b0);
    cur_dep = 1'b1; cur_incp = 1'b1;
    idle(1, 1'b0);
    mem(st(3'd0) | B_WR);
    push(st(3'd0) | B_PI, rnd());
    idle(3, 1'b0);
    cur_dep = 1'b0; cur_incp = 1'b0;
    idle(1, 1'b0);
    cur_incp = 1'b1;
    idle(1, 1'b0);
    push(st(3'd0) | B_PI, rnd());
    idle(2, 1'b0);
    cur_incp = 1'b0;
    idle(1, 1'b1);
    cur_dep = 1'b1;
    add_instr(3'd4, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    cur_dep = 1'b0;
    idle(1, 1'b0);
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL switches got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_step();
    logic [14:0] e, a, m;
    idle(1, 1'b0);
`ifdef Q2_SINGLE_STEP_EN
    cur_step = 1'b1; cur_dep = 1'b1;
    idle(1, 1'b0);
    cur_step = 1'b0;
    add_instr(3'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cur_dep = 1'b0;
    cur_step = 1'b1;
    idle(1, 1'b0);
    cur_step = 1'b0;
    add_instr(3'd2, 1'b1, 4'd2, 1'b0, 1'b0);
    idle(3, 1'b0);
`else
    cur_step = 1'b1;
    idle(4, 1'b0);
    cur_step = 1'b0;
    idle(2, 1'b0);
`endif
    while (exp_q.size() != 0) begin
      play_cycle(e, a, m);
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL step got=%h want=%h", a & m, e & m);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] e, a, m;
    int nshift;
    nshift = 0;
    idle(1, 1'b1);
    add_instr(3'd2, 1'b0, 4'd9, 1'b0, 1'b1);
    while (exp_q.size() != 0 && nshift < 5) begin
      play_cycle(e, a, m);
      if (e[14:12] == 3'd5) nshift++;
      checks++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL reset_lead got=%h want=%h", a & m, e & m);
      end
    end
    exp_q.delete();
    #1;
    rst = 1'b1;
    #1;
    a = {state_o, addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel};
    checks++;
    if (a !== 15'h0) begin
      fails++;
      $display("FAIL async_reset got=%h want=0000", a);
    end
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    a = {state_o, addr_sel, mem_rd, mem_wr, ir_wr, x_wr, a_wr, a_sel, p_wr, p_inc, f_wr, f_sel};
    checks++;
    if (a !== 15'h0) begin
      fails++;
      $display("FAIL after_reset_idle got=%h want=0000", a);
    end
  endtask

  initial begin
    test_reset();
    test_add_fast();
    test_shift();
    test_jumps();
    test_mem_wait();
    test_switches();
    test_step();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
